// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: datapath widths and the writeback entry
// carried between execute/memory stages and the register file.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with occupancy count; holds load results
// until the arbiter grants them the register-file write port.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              pop_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign pop_entry = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, buffered load results drain
// when idle or when starved; tracks outstanding loads in a busy scoreboard.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       write_data,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int unsigned CNT_W = $clog2(MEM_FIFO_DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             push_entry, head;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic                  force_drain, alu_sel;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign push_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH(MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .pop_entry (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign force_drain = !fifo_empty && (starve_q == STV_W'(STARVE_LIMIT));
  assign alu_ready   = !rst && !force_drain;
  assign mem_ready   = !rst && (fifo_count < CNT_W'(MEM_FIFO_DEPTH));
  assign push        = mem_valid && mem_ready;
  assign alu_sel     = alu_valid && alu_ready;
  assign pop         = !rst && !alu_sel && !fifo_empty;

  always_comb begin
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (alu_sel) begin
      reg_write_d  = (alu_rd != '0);
      rd_d         = alu_rd;
      write_data_d = alu_data;
    end else if (pop) begin
      reg_write_d  = (head.rd != '0);
      rd_d         = head.rd;
      write_data_d = head.data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_sel && (starve_q < STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Set is applied after clear so a same-register reissue keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (pop)      busy_d[head.rd]     = 1'b0;
    if (ld_issue) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      starve_q     <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      starve_q     <= starve_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;

  push_never_full : assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed timing checks plus a
// per-source scoreboard that verifies every register-file write in order.
module tb_writeback_arbiter;
  import riscv_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  alu_valid, alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid, mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  ld_issue;
  logic [REG_ADDR_W-1:0] ld_issue_rd;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       write_data;
  logic [NUM_REGS-1:0]   busy;

  writeback_arbiter #(
    .MEM_FIFO_DEPTH(4),
    .STARVE_LIMIT  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .ld_issue   (ld_issue),
    .ld_issue_rd(ld_issue_rd),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  int        alu_seq  = 0;
  wb_entry_t alu_q[$];
  wb_entry_t mem_q[$];
  wb_entry_t got, exp_e;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected writes come from accepted stimulus; each write is matched to its source queue.
  always @(negedge clk) begin
    if (rst) begin
      alu_q.delete();
      mem_q.delete();
    end else begin
      if (reg_write) begin
        got.rd   = rd;
        got.data = write_data;
        if (alu_q.size() != 0 && alu_q[0].data == write_data &&
            (mem_q.size() == 0 || mem_q[0].data != write_data)) begin
          exp_e = alu_q.pop_front();
          check_val("alu_wr", got, exp_e);
        end else if (mem_q.size() != 0) begin
          exp_e = mem_q.pop_front();
          check_val("mem_wr", got, exp_e);
        end else begin
          check_val("spurious_wr", 64'(reg_write), 64'd0);
        end
      end
      if (alu_valid && alu_ready && alu_rd != '0) alu_q.push_back('{rd: alu_rd, data: alu_data});
      if (mem_valid && mem_ready && mem_rd != '0) mem_q.push_back('{rd: mem_rd, data: mem_data});
    end
  end

  task automatic tick(output bit a_acc, output bit m_acc);
    #2;
    a_acc = alu_valid && alu_ready;
    m_acc = mem_valid && mem_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit a, m;
    tick(a, m);
  endtask

  task automatic next_alu();
    alu_seq++;
    alu_data = 32'hC0DE_0000 | XLEN'(alu_seq);
    alu_rd   = REG_ADDR_W'(1 + (alu_seq % 4));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a, m;
    int pushed;
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_reg_write", reg_write, 0);
    check_val("rst_rd", rd, 0);
    check_val("rst_wdata", write_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_alu_ready", alu_ready, 0);
    check_val("rst_mem_ready", mem_ready, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_mem_ready", mem_ready, 1);
    check_val("post_rst_alu_ready", alu_ready, 1);

    // ALU only, then rd==0
    alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_000F;
    tick(a, m);
    alu_valid = 0;
    check_val("alu_we", reg_write, 1);
    check_val("alu_rd", rd, 5);
    check_val("alu_data", write_data, 32'hF);
    alu_valid = 1; alu_rd = 0; alu_data = 32'h0000_001F;
    tick(a, m);
    alu_valid = 0;
    check_val("alu_x0_we", reg_write, 0);

    // Load lifecycle
    ld_issue = 1; ld_issue_rd = 6;
    step();
    ld_issue = 0;
    check_val("busy6_set", busy[6], 1);
    step();
    step();
    mem_valid = 1; mem_rd = 6; mem_data = 32'hA5A5_A5A5;
    tick(a, m);
    mem_valid = 0;
    check_val("ld_push_no_bypass", reg_write, 0);
    check_val("busy6_held", busy[6], 1);
    step();
    check_val("ld_we", reg_write, 1);
    check_val("ld_rd", rd, 6);
    check_val("ld_data", write_data, 32'hA5A5_A5A5);
    check_val("busy6_clr", busy[6], 0);

    // Load to x0 is consumed silently
    mem_valid = 1; mem_rd = 0; mem_data = 32'h5;
    step();
    mem_valid = 0;
    step();
    check_val("ld_x0_we", reg_write, 0);

    // Fill to full with the ALU always winning, then a forced drain
    next_alu();
    alu_valid = 1;
    mem_valid = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rd = REG_ADDR_W'(10 + k); mem_data = 32'hD000_0000 + k;
      tick(a, m);
      check_val("fill_push", m, 1);
      if (a) next_alu();
    end
    mem_valid = 0;
    check_val("full_mem_ready", mem_ready, 0);
    for (int i = 0; i < 5; i++) begin
      check_val("pre_drain_alu_ready", alu_ready, 1);
      tick(a, m);
      if (a) next_alu();
    end
    check_val("drain_alu_ready", alu_ready, 0);
    tick(a, m);
    check_val("drain_we", reg_write, 1);
    check_val("drain_rd", rd, 10);
    check_val("drain_data", write_data, 32'hD000_0000);
    check_val("resume_alu_ready", alu_ready, 1);
    check_val("resume_mem_ready", mem_ready, 1);
    tick(a, m);
    if (a) next_alu();
    alu_valid = 0;
    repeat (5) step();

    // Reissue of x9 on the edge that pops the load to x9
    ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_issue = 0;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h0000_0099;
    step();
    mem_valid = 0;
    ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_issue = 0;
    check_val("x9_pop_we", reg_write, 1);
    check_val("x9_pop_rd", rd, 9);
    check_val("x9_busy_kept", busy[9], 1);

    // Push and pop together at count 2
    next_alu();
    alu_valid = 1; mem_valid = 1; mem_rd = 21; mem_data = 32'hE000_0001;
    tick(a, m);
    if (a) next_alu();
    mem_rd = 22; mem_data = 32'hE000_0002;
    tick(a, m);
    if (a) next_alu();
    alu_valid = 0;
    mem_rd = 23; mem_data = 32'hE000_0003;
    step();
    mem_valid = 0;
    check_val("pp_first", write_data, 32'hE000_0001);
    step();
    check_val("pp_second", write_data, 32'hE000_0002);
    step();
    check_val("pp_third", write_data, 32'hE000_0003);
    step();
    check_val("pp_empty_we", reg_write, 0);

    // Wrap-around with random ALU interleave
    pushed = 0;
    mem_valid = 1; mem_rd = 11; mem_data = 1;
    next_alu();
    alu_valid = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 300 && pushed < 10; cyc++) begin
      tick(a, m);
      if (m) begin
        pushed++;
        if (pushed < 10) begin
          mem_rd = REG_ADDR_W'(11 + pushed); mem_data = XLEN'(pushed + 1);
        end else begin
          mem_valid = 0;
        end
      end
      if (a || !alu_valid) begin
        if (a) next_alu();
        alu_valid = 1'($urandom_range(0, 1));
      end
    end
    alu_valid = 0;
    mem_valid = 0;
    check_val("wrap_pushed", pushed, 10);
    for (int i = 0; i < 30 && (mem_q.size() != 0 || alu_q.size() != 0); i++) step();
    check_val("wrap_mem_drained", mem_q.size(), 0);
    check_val("wrap_alu_drained", alu_q.size(), 0);

    // Reset mid-stream with 3 FIFO entries and busy[7]
    ld_issue = 1; ld_issue_rd = 7;
    next_alu();
    alu_valid = 1; mem_valid = 1;
    for (int k = 0; k < 3; k++) begin
      mem_rd = REG_ADDR_W'(24 + k); mem_data = 32'hF000_0000 + k;
      tick(a, m);
      ld_issue = 0;
      if (a) next_alu();
    end
    mem_valid = 0; alu_valid = 0;
    check_val("pre_rst_busy7", busy[7], 1);
    rst = 1;
    step();
    check_val("mid_rst_we", reg_write, 0);
    check_val("mid_rst_rd", rd, 0);
    check_val("mid_rst_wdata", write_data, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_mem_ready", mem_ready, 0);
    check_val("mid_rst_alu_ready", alu_ready, 0);
    rst = 0;
    #1;
    check_val("after_rst_mem_ready", mem_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("after_rst_no_write", reg_write, 0);
    end
    check_val("end_mem_q", mem_q.size(), 0);
    check_val("end_alu_q", alu_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
